day11_seq_comparator_ctrl: RTL and testbench

//  Sequencer that compares two wide unsigned operands by time-multiplexing one
//  4-bit magnitude comparator stage, one nibble per clock, MSB nibble first.

---
 rtl/day11_seq_comparator_ctrl.sv | 125 ++++++++++++
 tb/tb_day11_seq_comparator_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/day11_seq_comparator_ctrl.sv
// Serial magnitude compare of two wide operands, one nibble per clock, MSB first.
// Stops at the first unequal nibble and pulses done with registered g/e/s.
//
//   state | meaning
//   IDLE  | waiting for start; results held from the last compare
//   CMP   | examining nibble r_idx of the latched operands
module day11_seq_comparator_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic                   g,
    output logic                   e,
    output logic                   s,
    output logic [4:0]             nib_cnt
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

    typedef enum logic {IDLE, CMP} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [IW-1:0]   r_idx;
    logic            r_done;
    logic            r_g;
    logic            r_e;
    logic            r_s;
    logic [4:0]      r_nib_cnt;

    logic [3:0]      w_na;
    logic [3:0]      w_nb;
    logic            w_ng;
    logic            w_ns;
    logic            w_last;
    logic            w_finish;

    // Nibble select mux feeding the single shared comparator stage.
    always_comb begin
        w_na = '0;
        w_nb = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == i[IW-1:0]) begin
                w_na = r_a[4*i +: 4];
                w_nb = r_b[4*i +: 4];
            end
        end
    end

    assign w_ng     = (w_na > w_nb);
    assign w_ns     = (w_na < w_nb);
    assign w_last   = (r_idx == '0);
    assign w_finish = (r_state == CMP) && (w_ng || w_ns || w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CMP;
            CMP:     if (w_finish) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_idx     <= '0;
            r_done    <= 1'b0;
            r_g       <= 1'b0;
            r_e       <= 1'b0;
            r_s       <= 1'b0;
            r_nib_cnt <= '0;
        end else begin
            r_done <= w_finish;
            if (r_state == IDLE) begin
                if (start) begin
                    r_a       <= a;
                    r_b       <= b;
                    r_idx     <= IDX_TOP;
                    r_g       <= 1'b0;
                    r_e       <= 1'b0;
                    r_s       <= 1'b0;
                    r_nib_cnt <= '0;
                end
            end else begin
                r_nib_cnt <= r_nib_cnt + 5'd1;
                if (w_ng) begin
                    r_g <= 1'b1;
                end else if (w_ns) begin
                    r_s <= 1'b1;
                end else if (w_last) begin
                    r_e <= 1'b1;
                end else begin
                    r_idx <= r_idx - 1'b1;
                end
            end
        end
    end

    assign busy    = (r_state == CMP);
    assign done    = r_done;
    assign g       = r_g;
    assign e       = r_e;
    assign s       = r_s;
    assign nib_cnt = r_nib_cnt;

endmodule

// File: tb/tb_day11_seq_comparator_ctrl.sv
// Bench for the serial nibble comparator: directed cases plus randomised
// operations on a 4-nibble and a 1-nibble instance against an arithmetic model.
module tb_day11_seq_comparator_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st4, st1;
    logic [15:0] a4, b4;
    logic [3:0]  a1, b1;

    logic        busy4, done4, g4, e4, s4;
    logic [4:0]  nib4;
    logic        busy1, done1, g1, e1, s1;
    logic [4:0]  nib1;

    logic        sel1;
    logic        o_busy, o_done;
    logic [2:0]  o_ges;
    logic [4:0]  o_nib;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    day11_seq_comparator_ctrl #(.NIBBLES(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .g(g4), .e(e4), .s(s4), .nib_cnt(nib4)
    );

    day11_seq_comparator_ctrl #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .g(g1), .e(e1), .s(s1), .nib_cnt(nib1)
    );

    always_comb begin
        o_busy = sel1 ? busy1 : busy4;
        o_done = sel1 ? done1 : done4;
        o_ges  = sel1 ? {g1, e1, s1} : {g4, e4, s4};
        o_nib  = sel1 ? nib1 : nib4;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // k = nibbles examined: all of them if equal, else down to the nibble
    // holding the most significant differing bit.
    function automatic void model(input logic [15:0] a, input logic [15:0] b, input int n,
                                  output int k, output logic [2:0] ges);
        logic [15:0] d;
        int msb;
        d   = a ^ b;
        ges = {a > b, a == b, a < b};
        if (d == 16'd0) begin
            k = n;
        end else begin
            msb = $clog2(int'(d) + 1) - 1;
            k   = n - msb / 4;
        end
    endfunction

    // Called at the negedge right after the accepting edge.
    task automatic finish_op(input int k, input logic [2:0] ges, input string tag);
        int cnt   = 0;
        int guard = 0;
        while (!o_done && guard < 40) begin
            if (o_busy) begin
                cnt++;
                chk({tag, " ges_clear_busy"}, {29'd0, o_ges}, 32'd0);
            end
            guard++;
            @(negedge clk);
        end
        chk({tag, " done_seen"}, {31'd0, o_done}, 32'd1);
        chk({tag, " busy_at_done"}, {31'd0, o_busy}, 32'd0);
        chk({tag, " ges"}, {29'd0, o_ges}, {29'd0, ges});
        chk({tag, " nib_cnt"}, {27'd0, o_nib}, k);
        chk({tag, " busy_cycles"}, cnt, k);
    endtask

    task automatic run_op(input bit one, input logic [15:0] a, input logic [15:0] b,
                          input string tag);
        int k;
        logic [2:0] ges;
        logic [15:0] aa, bb;
        aa   = one ? {12'd0, a[3:0]} : a;
        bb   = one ? {12'd0, b[3:0]} : b;
        model(aa, bb, one ? 1 : 4, k, ges);
        sel1 = one;
        if (one) begin a1 = aa[3:0]; b1 = bb[3:0]; st1 = 1'b1; end
        else     begin a4 = aa;      b4 = bb;      st4 = 1'b1; end
        @(negedge clk);
        st1 = 1'b0; st4 = 1'b0;
        a4 = 16'($urandom); b4 = 16'($urandom);
        a1 = 4'($urandom);  b1 = 4'($urandom);
        finish_op(k, ges, tag);
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'd0, o_done}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1);
    end

    initial begin
        logic [15:0] ra, rb;
        int mode;
        rst_n = 1'b0; st4 = 1'b0; st1 = 1'b0;
        a4 = '0; b4 = '0; a1 = '0; b1 = '0; sel1 = 1'b0;
        #2;
        chk("reset outs4", {26'd0, busy4, done4, g4, e4, s4, nib4}, 32'd0);
        chk("reset outs1", {26'd0, busy1, done1, g1, e1, s1, nib1}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(0, 16'h1234, 16'h1234, "t1_equal");
        run_op(0, 16'h8000, 16'h7FFF, "t2_msb_gt");
        run_op(0, 16'h12F3, 16'h12F4, "t3_lsb_lt");
        run_op(0, 16'hA5C0, 16'hA4FF, "t3_nib2_gt");
        run_op(0, 16'h0000, 16'hFFFF, "edge_zero_max");
        run_op(0, 16'hFFFF, 16'hFFFF, "edge_max_eq");

        // Start held high, inputs churned while busy, back-to-back accept.
        sel1 = 1'b0;
        a4 = 16'h5A5A; b4 = 16'h5A5A; st4 = 1'b1;
        @(negedge clk);
        a4 = 16'h0F00; b4 = 16'hF000;
        finish_op(4, 3'b010, "t4_first");
        a4 = 16'hA5C0; b4 = 16'hA4FF;
        @(negedge clk);
        st4 = 1'b0;
        chk("t4 b2b busy", {31'd0, busy4}, 32'd1);
        chk("t4 b2b ges_cleared", {29'd0, g4, e4, s4}, 32'd0);
        chk("t4 b2b nib_cleared", {27'd0, nib4}, 32'd0);
        finish_op(2, 3'b100, "t4_second");
        @(negedge clk);
        chk("t4 done_pulse", {31'd0, done4}, 32'd0);

        // Reset in the 2nd CMP cycle abandons the compare.
        a4 = 16'h1234; b4 = 16'h1234; st4 = 1'b1;
        @(negedge clk);
        st4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t5 reset_outs", {26'd0, busy4, done4, g4, e4, s4, nib4}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t5 no_done", {31'd0, done4}, 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_op(0, 16'h1234, 16'h1234, "t5_after_rst");

        run_op(1, 16'h0003, 16'h0009, "t6_n1_lt");
        run_op(1, 16'h0007, 16'h0007, "t6_n1_eq");
        run_op(1, 16'h000F, 16'h0000, "t6_n1_gt");

        for (int i = 0; i < 1000; i++) begin
            ra   = 16'($urandom);
            mode = $urandom_range(0, 3);
            case (mode)
                0:       rb = 16'($urandom);
                1:       rb = ra;
                2:       rb = ra ^ (16'd1 << $urandom_range(0, 15));
                default: rb = {ra[15:4], 4'($urandom)};
            endcase
            run_op(i >= 600, ra, rb, (i >= 600) ? "rnd_n1" : "rnd_n4");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
